// File: rtl/lcd_bus_writer.sv
// HD44780 bus write-cycle generator: valid/ready request in, timed RS/DB/E cycle out.
// Define LCD_4BIT_EN for a 4-bit bus (two nibble strobes on LcdData[7:4]); otherwise 8-bit.
module lcd_bus_writer #(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 1,
  parameter int WAIT_SHORT_CYC = 2000,
  parameter int WAIT_LONG_CYC  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  output logic       InReady,
  input  logic       InRS,
  input  logic [7:0] InData,
  output logic       Busy,
  output logic       LcdE,
  output logic       LcdRS,
  output logic       LcdRW,
  output logic [7:0] LcdData
);

  localparam int CW = 17;

  // Counters load N-1 on state entry and leave the state when they read zero.
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] E_LOAD     = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SHORT_LOAD = CW'(WAIT_SHORT_CYC - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(WAIT_LONG_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          rs_reg, rs_next;
  logic [7:0]    byte_reg, byte_next;
  logic          lcd_e_next;
  logic          lcd_rs_next;
  logic [7:0]    lcd_data_next;
  logic          ready_next;
  logic          cnt_zero;
  logic          long_cmd;
`ifdef LCD_4BIT_EN
  logic          nib_reg, nib_next;
`endif

  assign cnt_zero = (cnt_reg == '0);

  // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution time.
  assign long_cmd = !rs_reg && (byte_reg[7:2] == 6'd0) && (byte_reg[1:0] != 2'd0);

  // Write-only interface: R/W is tied low.
  assign LcdRW = 1'b0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rs_reg    <= 1'b0;
      byte_reg  <= 8'h00;
      LcdE      <= 1'b0;
      LcdRS     <= 1'b0;
      LcdData   <= 8'h00;
      InReady   <= 1'b1;
      Busy      <= 1'b0;
`ifdef LCD_4BIT_EN
      nib_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rs_reg    <= rs_next;
      byte_reg  <= byte_next;
      LcdE      <= lcd_e_next;
      LcdRS     <= lcd_rs_next;
      LcdData   <= lcd_data_next;
      InReady   <= ready_next;
      Busy      <= ~ready_next;
`ifdef LCD_4BIT_EN
      nib_reg   <= nib_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rs_next       = rs_reg;
    byte_next     = byte_reg;
    lcd_e_next    = LcdE;
    lcd_rs_next   = LcdRS;
    lcd_data_next = LcdData;
    ready_next    = InReady;
`ifdef LCD_4BIT_EN
    nib_next      = nib_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (InValid && InReady) begin
          state_next  = S_SETUP;
          cnt_next    = SETUP_LOAD;
          rs_next     = InRS;
          byte_next   = InData;
          lcd_rs_next = InRS;
          ready_next  = 1'b0;
`ifdef LCD_4BIT_EN
          nib_next      = 1'b0;
          lcd_data_next = {InData[7:4], 4'b0000};
`else
          lcd_data_next = InData;
`endif
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          state_next = S_PULSE;
          cnt_next   = E_LOAD;
          lcd_e_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      S_PULSE: begin
        if (cnt_zero) begin
          state_next = S_HOLD;
          cnt_next   = HOLD_LOAD;
          lcd_e_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      S_HOLD: begin
        if (cnt_zero) begin
`ifdef LCD_4BIT_EN
          // After the high nibble, run a second strobe for the low nibble.
          if (!nib_reg) begin
            state_next    = S_SETUP;
            cnt_next      = SETUP_LOAD;
            nib_next      = 1'b1;
            lcd_data_next = {byte_reg[3:0], 4'b0000};
          end else begin
            state_next = S_EXEC;
            cnt_next   = long_cmd ? LONG_LOAD : SHORT_LOAD;
          end
`else
          state_next = S_EXEC;
          cnt_next   = long_cmd ? LONG_LOAD : SHORT_LOAD;
`endif
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      S_EXEC: begin
        if (cnt_zero) begin
          state_next = S_IDLE;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        lcd_e_next = 1'b0;
        ready_next = 1'b1;
      end
    endcase
  end

endmodule
